// File: rtl/sr_lifo.sv
// Parametrised hardware stack beside the register file.
// Combinational top/peek reads, replace-top, flush and sticky error flags.
module sr_lifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] din,
  input  logic [IW-1:0]    peek_idx,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] peek,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int CW = LW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mem_we;
  logic [IW-1:0]    mem_wa;
  logic [IW-1:0]    top_a;
  logic [IW-1:0]    peek_a;
  logic             is_empty;
  logic             is_full;
  logic             peek_ok;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LW'(DEPTH));

  // level-1 is only formed when level>0, so no index ever wraps
  assign top_a   = is_empty ? '0
                 : IW'(level_q - LW'(1));
  assign peek_ok = CW'(peek_idx) < CW'(level_q);
  assign peek_a  = peek_ok
                 ? IW'(level_q - LW'(1) - LW'(peek_idx))
                 : '0;

  assign top   = is_empty ? '0 : mem_q[top_a];
  assign peek  = peek_ok ? mem_q[peek_a] : '0;
  assign level = level_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    mem_we  = 1'b0;
    mem_wa  = top_a;
    priority case (1'b1)
      clear: level_d = '0;
      push && pop: begin
        // empty push+pop: the pop is satisfied by the push
        if (!is_empty) begin
          mem_we = 1'b1;
          mem_wa = top_a;
        end
      end
      push: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          mem_wa  = IW'(level_q);
          level_d = level_q + LW'(1);
        end
      end
      pop: begin
        if (is_empty) unf_d = 1'b1;
        else level_d = level_q - LW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_wa] <= din;
  end

endmodule

// File: tb/tb_sr_lifo.sv
// Self-checking bench for sr_lifo: a DEPTH=4/WIDTH=8 instance
// and a DEPTH=5/WIDTH=32 instance, with a LIFO scoreboard.
module tb_sr_lifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       push, pop, clear, err_clr;
  logic [7:0] din;
  logic [1:0] peek_idx;
  logic [7:0] top, peek;
  logic [2:0] level;
  logic       empty, full, ovf, unf;

  logic        p5_push, p5_pop, p5_clear, p5_err_clr;
  logic [31:0] p5_din;
  logic [2:0]  p5_peek_idx;
  logic [31:0] p5_top, p5_peek;
  logic [2:0]  p5_level;
  logic        p5_empty, p5_full, p5_ovf, p5_unf;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  sr_lifo #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .push(push), .pop(pop),
    .clear(clear), .err_clr(err_clr),
    .din(din), .peek_idx(peek_idx),
    .top(top), .peek(peek),
    .level(level), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf)
  );

  sr_lifo #(.WIDTH(32), .DEPTH(5)) u5 (
    .clk(clk), .rst_n(rst_n),
    .push(p5_push), .pop(p5_pop),
    .clear(p5_clear), .err_clr(p5_err_clr),
    .din(p5_din), .peek_idx(p5_peek_idx),
    .top(p5_top), .peek(p5_peek),
    .level(p5_level), .empty(p5_empty),
    .full(p5_full), .ovf(p5_ovf), .unf(p5_unf)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; clear = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    din = 0; peek_idx = 0;
    p5_push = 0; p5_pop = 0; p5_clear = 0;
    p5_err_clr = 0; p5_din = 0; p5_peek_idx = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({level, empty, full, ovf, unf} !== {3'd0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_flags got %h %b%b%b%b exp 0 1000",
               level, empty, full, ovf, unf);
    end
    checks++;
    if ({top, peek} !== 16'h0) begin
      errors++;
      $display("FAIL reset_read got %h/%h exp 0/0", top, peek);
    end
    cyc(); cyc();
    @(negedge clk) rst_n = 1;
    cyc();
    checks++;
    if (level !== 0 || empty !== 1 || top !== 0) begin
      errors++;
      $display("FAIL reset_idle got lvl %0d empty %b top %h exp 0 1 0",
               level, empty, top);
    end
  endtask

  task automatic test_push_full();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push = 1; din = vals[i];
      cyc();
      sb.push_back(vals[i]);
    end
    push = 0; peek_idx = 3;
    #1;
    checks++;
    if (level !== 4 || full !== 1 || top !== sb[$]) begin
      errors++;
      $display("FAIL push_full got lvl %0d full %b top %h exp 4 1 %h",
               level, full, top, sb[$]);
    end
    checks++;
    if (peek !== sb[0]) begin
      errors++;
      $display("FAIL peek_bottom got %h exp %h", peek, sb[0]);
    end
    push = 1; din = 8'h55;
    cyc();
    push = 0;
    checks++;
    if (ovf !== 1 || top !== 8'h44 || level !== 4) begin
      errors++;
      $display("FAIL push_ovf got ovf %b top %h lvl %0d exp 1 44 4",
               ovf, top, level);
    end
  endtask

  task automatic test_pop();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      pop = 1;
      #1;
      exp = sb.pop_back();
      checks++;
      if (top !== exp) begin
        errors++;
        $display("FAIL pop_top%0d got %h exp %h", i, top, exp);
      end
      cyc();
    end
    pop = 0;
    checks++;
    if (level !== 0 || empty !== 1 || top !== 0) begin
      errors++;
      $display("FAIL pop_empty got lvl %0d empty %b top %h exp 0 1 0",
               level, empty, top);
    end
    pop = 1;
    cyc();
    pop = 0;
    checks++;
    if (unf !== 1 || level !== 0) begin
      errors++;
      $display("FAIL pop_unf got unf %b lvl %0d exp 1 0", unf, level);
    end
  endtask

  task automatic test_replace();
    err_clr = 1;
    cyc();
    err_clr = 0;
    push = 1; din = 8'hA0;
    cyc();
    pop = 1; din = 8'hB0;
    cyc();
    idle();
    checks++;
    if (level !== 1 || top !== 8'hB0) begin
      errors++;
      $display("FAIL replace_one got lvl %0d top %h exp 1 b0", level, top);
    end
    for (int i = 0; i < 3; i++) begin
      push = 1; din = 8'h60 + 8'(i);
      cyc();
    end
    push = 1; pop = 1; din = 8'hC0;
    cyc();
    idle();
    checks++;
    if (top !== 8'hC0 || level !== 4 || ovf !== 0) begin
      errors++;
      $display("FAIL replace_full got top %h lvl %0d ovf %b exp c0 4 0",
               top, level, ovf);
    end
    peek_idx = 1;
    #1;
    checks++;
    if (peek !== 8'h61) begin
      errors++;
      $display("FAIL replace_peek got %h exp 61", peek);
    end
  endtask

  task automatic test_errors();
    push = 1; din = 8'hEE;
    cyc();
    push = 0;
    checks++;
    if (ovf !== 1) begin
      errors++;
      $display("FAIL err_set got ovf %b exp 1", ovf);
    end
    err_clr = 1;
    cyc();
    err_clr = 0;
    checks++;
    if (ovf !== 0) begin
      errors++;
      $display("FAIL err_clr got ovf %b exp 0", ovf);
    end
    err_clr = 1; push = 1;
    cyc();
    idle();
    checks++;
    if (ovf !== 1 || top !== 8'hC0) begin
      errors++;
      $display("FAIL err_set_wins got ovf %b top %h exp 1 c0", ovf, top);
    end
    clear = 1; err_clr = 1;
    cyc();
    idle();
    push = 1; pop = 1; din = 8'h99;
    cyc();
    idle();
    checks++;
    if (level !== 0 || unf !== 0 || ovf !== 0 || top !== 0) begin
      errors++;
      $display("FAIL empty_pushpop got lvl %0d unf %b ovf %b top %h exp 0 0 0 0",
               level, unf, ovf, top);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1; din = 8'h30 + 8'(i);
      cyc();
    end
    checks++;
    if (level !== 3) begin
      errors++;
      $display("FAIL pre_reset got lvl %0d exp 3", level);
    end
    rst_n = 0;
    #1;
    checks++;
    if (level !== 0 || empty !== 1 || top !== 0) begin
      errors++;
      $display("FAIL async_reset got lvl %0d empty %b top %h exp 0 1 0",
               level, empty, top);
    end
    cyc();
    push = 0;
    @(negedge clk) rst_n = 1;
    cyc();
    checks++;
    if (level !== 0) begin
      errors++;
      $display("FAIL reset_abort got lvl %0d exp 0", level);
    end
  endtask

  task automatic test_flush_depth5();
    for (int i = 0; i < 3; i++) begin
      p5_push = 1; p5_din = 32'h1000 + i;
      cyc();
    end
    p5_clear = 1; p5_din = 32'hDEAD;
    cyc();
    p5_clear = 0; p5_push = 0;
    checks++;
    if (p5_level !== 0 || p5_ovf !== 0 || p5_unf !== 0) begin
      errors++;
      $display("FAIL flush got lvl %0d ovf %b unf %b exp 0 0 0",
               p5_level, p5_ovf, p5_unf);
    end
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      p5_push = 1; p5_din = 32'hCAFE_0000 + i;
      cyc();
      sb.push_back(8'(i));
    end
    p5_push = 0; p5_peek_idx = 6;
    #1;
    checks++;
    if (p5_full !== 1 || p5_level !== 5 || p5_top !== 32'hCAFE_0004) begin
      errors++;
      $display("FAIL d5_full got full %b lvl %0d top %h exp 1 5 cafe0004",
               p5_full, p5_level, p5_top);
    end
    checks++;
    if (p5_peek !== 0) begin
      errors++;
      $display("FAIL d5_peek_oob got %h exp 0", p5_peek);
    end
    p5_peek_idx = 4;
    #1;
    checks++;
    if (p5_peek !== 32'hCAFE_0000 + 32'(sb[0])) begin
      errors++;
      $display("FAIL d5_peek_bottom got %h exp cafe0000", p5_peek);
    end
    p5_peek_idx = 5;
    #1;
    checks++;
    if (p5_peek !== 0) begin
      errors++;
      $display("FAIL d5_peek_level got %h exp 0", p5_peek);
    end
  endtask

  initial begin
    test_reset();
    test_push_full();
    test_pop();
    test_replace();
    test_errors();
    test_async_reset();
    test_flush_depth5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_lifo.md
Name: sr_lifo

Overview:
sr_lifo is a parametrised hardware stack (LIFO) for the schoolRISCV core, replacing the fixed 8-entry by 8-bit stack used by the PUSH/POP instructions.
- Generalises data width and depth.
- Adds a synchronous flush, a push+pop replace-top operation, indexed peek below the top, an occupancy count, and sticky overflow/underflow flags.
- Sits beside the register file: push data comes from rs1, and the top/peek outputs feed the write-back mux.

Parameters:
- WIDTH, 32: data width in bits; must be >= 1.
- DEPTH, 8: number of entries; must be >= 2; power of two not required.
- Derived localparams (not overridable):
  - LW = $clog2(DEPTH+1): level counter width.
  - IW = $clog2(DEPTH): peek index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  push din this cycle.
- pop  in  1  pop top entry this cycle.
- clear  in  1  synchronous flush of the stack.
- err_clr  in  1  clear the sticky error flags.
- din  in  WIDTH  push data.
- peek_idx  in  IW  entry to read; 0 = top, 1 = one below top, and so on.
- top  out  WIDTH  current top entry; 0 when empty.
- peek  out  WIDTH  entry selected by peek_idx; 0 if that entry is not valid.
- level  out  LW  number of valid entries, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- ovf  out  1  sticky: a push was attempted while full.
- unf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous, no clock required):
  - level=0, empty=1, full=0, ovf=0, unf=0.
  - top=0 and peek=0, because no entry is valid.
  - Storage array is not reset.
  - Reset asserted mid-operation aborts any pending update.
- Read path (combinational from registered state, 0-cycle latency):
  - top = mem[level-1] when level>0, else 0.
  - peek = mem[level-1-peek_idx] when peek_idx < level, else 0.
  - A pop consumer samples top in the same cycle pop is asserted.
  - Pushed data appears on top the cycle after the push edge.
- Index arithmetic never wraps. Every level-1 access is guarded by level>0.
- Operation per rising edge; clear has top priority:
  - clear=1: level<=0. push and pop are ignored and no error flags are set. err_clr is still honoured.
  - push only, not full: mem[level]<=din; level<=level+1.
  - push only, full: push dropped; contents and level unchanged; ovf<=1.
  - pop only, not empty: level<=level-1. The storage word is left stale.
  - pop only, empty: no state change; unf<=1.
  - push and pop, not empty: replace top, mem[level-1]<=din; level unchanged. No flags, even when full.
  - push and pop, empty: no state change; no flags. The pop is satisfied by the concurrent push.
  - neither: hold.
- Sticky flags:
  - Each flag is set by its event and held until err_clr=1 at an edge.
  - If err_clr coincides with a new error event, the set wins (flag stays 1), so no event is lost.
- empty and full are decoded from level and never disagree with it.
- Exactly one storage word is written per cycle at most. No read-during-write hazards exist, because reads are combinational from current state.

Test Plan (WIDTH=8, DEPTH=4 unless stated):
- Reset then idle -> level=0, empty=1, full=0, top=0, peek=0, ovf=0, unf=0. Assert rst_n low mid-stream with level=3 -> level=0 immediately, without waiting for a clock edge.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> after the last push level=4, full=1, top=0x44. With peek_idx=3, peek=0x11. Push 0x55 -> dropped, ovf=1, top=0x44, level=4.
- From the full state, pop 4 times -> top reads 0x44, 0x33, 0x22, 0x11 in the pop cycles, then level=0, empty=1, top=0. A fifth pop -> unf=1, level stays 0.
- Push 0xA0, then push+pop with din=0xB0 -> level=1, top=0xB0. With the stack full, push+pop with din=0xC0 -> top=0xC0, level=4, ovf stays 0.
- Error flags: with ovf=1, pulse err_clr alone -> ovf=0. With the stack full, assert err_clr and push together -> ovf remains 1. With empty, push+pop -> level=0, unf=0.
- Flush and DEPTH=5, WIDTH=32: with level=3, assert clear together with push -> level=0 and no flags set. Then push 5 words -> full=1 at level=5 (non-power-of-two depth), and peek_idx=6 gives peek=0.
